// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix read-port sharing logic.
package matrix_pkg;

  localparam int MRA_NUM_REQ        = 4;
  localparam int MRA_ADDR_WIDTH     = 3;
  localparam int MRA_DATA_WIDTH     = 160;
  localparam int MRA_MEMORY_LATENCY = 2;

  // Successor of a requester index with explicit wrap, so N need not be a power of two.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/matrix_read_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward with
// wrap-around; the pointer moves past the winner when a grant is taken.
module rr_arbiter
  import matrix_pkg::*;
#(
  parameter int N = MRA_NUM_REQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;

  // Two-pass priority search: indices at/after the pointer first, then the ones before it.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr_q))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        ptr_d    = PW'(rr_next(i, N));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i < int'(ptr_q))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        ptr_d    = PW'(rr_next(i, N));
      end
    end
  end

  // Pointer register; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/matrix_read_arbiter.sv
// Shares one matrix read port between NUM_REQ requesters. Issued reads carry a
// one-hot requester tag through a MEMORY_LATENCY-deep shift register so that
// each memory response is steered back to the requester that asked for it.
module matrix_read_arbiter
  import matrix_pkg::*;
#(
  parameter int NUM_REQ        = MRA_NUM_REQ,
  parameter int ADDR_WIDTH     = MRA_ADDR_WIDTH,
  parameter int DATA_WIDTH     = MRA_DATA_WIDTH,
  parameter int MEMORY_LATENCY = MRA_MEMORY_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_addr_ready,
  input  logic                          mem_valid,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          protocol_err
);

  typedef struct packed {
    logic               vld;
    logic [NUM_REQ-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0]    req_gated;
  logic [NUM_REQ-1:0]    grant;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;

  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_addr_ready_q, mem_addr_ready_d;
  logic [NUM_REQ-1:0]    issue_id_q, issue_id_d;

  tag_t                  tag_q [MEMORY_LATENCY];
  tag_t                  tag_d [MEMORY_LATENCY];
  tag_t                  tail;

  logic                  mismatch;
  logic                  protocol_err_q, protocol_err_d;

  // Requests are masked while in reset so no grant (and no pointer move) can occur then.
  assign req_gated = rst ? req_valid : '0;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_gated),
    .advance (rst),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Address mux driven by the one-hot grant.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Issue stage next state: address holds between issues, the winner id rides along.
  always_comb begin
    mem_addr_d       = accept ? sel_addr : mem_addr_q;
    mem_addr_ready_d = accept;
    issue_id_d       = grant;
  end

  // Issue stage registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_addr_q       <= '0;
      mem_addr_ready_q <= 1'b0;
      issue_id_q       <= '0;
    end else begin
      mem_addr_q       <= mem_addr_d;
      mem_addr_ready_q <= mem_addr_ready_d;
      issue_id_q       <= issue_id_d;
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_addr_ready = mem_addr_ready_q;

  // Tag shift: stage 0 captures the read presented to the memory this cycle.
  always_comb begin
    tag_d[0].vld = mem_addr_ready_q;
    tag_d[0].id  = issue_id_q;
    for (int s = 1; s < MEMORY_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // Tag pipeline registers; reset discards every in-flight read.
  always_ff @(posedge clk) begin
    for (int s = 0; s < MEMORY_LATENCY; s++) begin
      if (!rst) begin
        tag_q[s] <= '0;
      end else begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  // Tail stage lines up with mem_valid; a disagreement suppresses the response.
  always_comb begin
    tail           = tag_q[MEMORY_LATENCY-1];
    mismatch       = rst && (tail.vld != mem_valid);
    resp_valid     = (rst && tail.vld && mem_valid) ? tail.id : '0;
    resp_data      = rst ? mem_data : '0;
    protocol_err_d = protocol_err_q | mismatch;
  end

  // Sticky protocol error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      protocol_err_q <= 1'b0;
    end else begin
      protocol_err_q <= protocol_err_d;
    end
  end

  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_matrix_read_arbiter.sv
// Directed bench for matrix_read_arbiter: latency-2 instance for directed
// steps, plus latency-1 and latency-4 instances for the scoreboard phase.
module tb_matrix_read_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [11:0]  req_addr;
  logic         inject;

  logic [3:0]   rr_2, rr_1, rr_4;
  logic [2:0]   ma_2, ma_1, ma_4;
  logic         mar_2, mar_1, mar_4;
  logic         mv_2, mv_1, mv_4;
  logic [159:0] md_2, md_1, md_4;
  logic [3:0]   rv_2, rv_1, rv_4;
  logic [159:0] rd_2, rd_1, rd_4;
  logic         pe_2, pe_1, pe_4;

  int checks;
  int failures;

  function automatic logic [159:0] rowdat(input logic [2:0] a);
    logic [7:0] b;
    b = 8'hA0 | {5'd0, a};
    return {20{b}};
  endfunction

  function automatic logic [3:0] rr_pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return 4'(1 << ((p + k) % 4));
    end
    return 4'd0;
  endfunction

  matrix_read_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(3), .DATA_WIDTH(160), .MEMORY_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rr_2),
    .mem_addr(ma_2), .mem_addr_ready(mar_2), .mem_valid(mv_2), .mem_data(md_2),
    .resp_valid(rv_2), .resp_data(rd_2), .protocol_err(pe_2));

  matrix_read_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(3), .DATA_WIDTH(160), .MEMORY_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rr_1),
    .mem_addr(ma_1), .mem_addr_ready(mar_1), .mem_valid(mv_1), .mem_data(md_1),
    .resp_valid(rv_1), .resp_data(rd_1), .protocol_err(pe_1));

  matrix_read_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(3), .DATA_WIDTH(160), .MEMORY_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rr_4),
    .mem_addr(ma_4), .mem_addr_ready(mar_4), .mem_valid(mv_4), .mem_data(md_4),
    .resp_valid(rv_4), .resp_data(rd_4), .protocol_err(pe_4));

  // Matrix memory models: fixed read latency, reset together with the DUT.
  logic       pv2 [2];
  logic [2:0] pa2 [2];
  logic       pv1;
  logic [2:0] pa1;
  logic       pv4 [4];
  logic [2:0] pa4 [4];

  always @(posedge clk) begin
    if (!rst) begin
      pv2[0] <= 1'b0; pv2[1] <= 1'b0;
      pv1    <= 1'b0;
      for (int s = 0; s < 4; s++) pv4[s] <= 1'b0;
    end else begin
      pv2[0] <= mar_2; pa2[0] <= ma_2;
      pv2[1] <= pv2[0]; pa2[1] <= pa2[0];
      pv1 <= mar_1; pa1 <= ma_1;
      pv4[0] <= mar_4; pa4[0] <= ma_4;
      for (int s = 1; s < 4; s++) begin
        pv4[s] <= pv4[s-1]; pa4[s] <= pa4[s-1];
      end
    end
  end

  assign mv_2 = pv2[1] | inject;
  assign md_2 = rowdat(pa2[1]);
  assign mv_1 = pv1;
  assign md_1 = rowdat(pa1);
  assign mv_4 = pv4[3];
  assign md_4 = rowdat(pa4[3]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] sid1 [0:79];
  logic [3:0] sid2 [0:79];
  logic [3:0] sid4 [0:79];
  logic [2:0] sad1 [0:79];
  logic [2:0] sad2 [0:79];
  logic [2:0] sad4 [0:79];

  initial begin
    int ptr_m;
    int idx;
    logic [3:0] g;
    logic [2:0] a;
    checks = 0; failures = 0;
    rst = 1'b0; req_valid = 4'hF; req_addr = 12'd0; inject = 1'b0;

    // Reset state
    tick; tick;
    #1;
    chk("rst_req_ready", rr_2, 0);
    chk("rst_mem_addr_ready", mar_2, 0);
    chk("rst_mem_addr", ma_2, 0);
    chk("rst_resp_valid", rv_2, 0);
    chk("rst_resp_data", rd_2, 0);
    chk("rst_protocol_err", pe_2, 0);
    rst = 1'b1; req_valid = 4'h0;
    #1;
    chk("idle_req_ready", rr_2, 0);
    tick;

    // Fairness: all four requesting for 8 cycles, then drain
    req_addr = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int k = 0; k < 11; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      chk("fair_ready", rr_2, (k < 8) ? (1 << (k % 4)) : 0);
      chk("fair_mar", mar_2, (k >= 1 && k <= 8) ? 1 : 0);
      chk("fair_maddr", ma_2, (k == 0) ? 0 : ((k <= 8) ? ((k - 1) % 4) + 1 : 4));
      chk("fair_resp", rv_2, (k >= 3) ? (1 << ((k - 3) % 4)) : 0);
      if (k >= 3) chk("fair_data", rd_2, rowdat(3'(((k - 3) % 4) + 1)));
      tick;
    end
    #1;
    chk("fair_perr", pe_2, 0);

    // Single requester 2, addresses 5,6,7 back to back
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 3) ? 4'b0100 : 4'b0000;
      req_addr  = (k < 3) ? {3'd0, 3'(5 + k), 6'd0} : 12'd0;
      #1;
      chk("single_ready", rr_2, (k < 3) ? 4'b0100 : 4'b0000);
      chk("single_mar", mar_2, (k >= 1 && k <= 3) ? 1 : 0);
      chk("single_maddr", ma_2, (k == 0) ? 4 : ((k <= 3) ? 4 + k : 7));
      chk("single_resp", rv_2, (k >= 3) ? 4'b0100 : 4'b0000);
      if (k >= 3) chk("single_data", rd_2, rowdat(3'(5 + k - 3)));
      tick;
    end

    // Wrap/skip: pointer is 3, requesters 0 and 1 active
    req_addr = {3'd0, 3'd0, 3'd2, 3'd1};
    for (int k = 0; k < 5; k++) begin
      req_valid = (k < 2) ? 4'b0011 : 4'b0000;
      #1;
      chk("wrap_ready", rr_2, (k == 0) ? 4'b0001 : ((k == 1) ? 4'b0010 : 4'b0000));
      chk("wrap_resp", rv_2, (k == 3) ? 4'b0001 : ((k == 4) ? 4'b0010 : 4'b0000));
      if (k >= 3) chk("wrap_data", rd_2, rowdat(3'(k - 2)));
      tick;
    end

    // Reset with two reads in flight (pointer starts at 2)
    req_addr = {3'd0, 3'd3, 3'd0, 3'd6};
    req_valid = 4'hF;
    #1; chk("mrst_g0", rr_2, 4'b0100);
    tick;
    req_valid = 4'b0001;
    #1; chk("mrst_g1", rr_2, 4'b0001);
    tick;
    rst = 1'b0; req_valid = 4'hF;
    #1; chk("mrst_ready_in_rst", rr_2, 0);
    tick;
    rst = 1'b1; req_valid = 4'h0;
    #1;
    chk("mrst_resp0", rv_2, 0);
    chk("mrst_mar", mar_2, 0);
    tick;
    #1;
    chk("mrst_resp1", rv_2, 0);
    chk("mrst_perr", pe_2, 0);
    tick;
    req_valid = 4'hF;
    #1; chk("mrst_ptr0", rr_2, 4'b0001);
    tick;
    req_valid = 4'h0;
    #1;
    chk("mrst_mar2", mar_2, 1);
    chk("mrst_maddr2", ma_2, 6);
    tick; tick;
    #1;
    chk("mrst_resp2", rv_2, 4'b0001);
    chk("mrst_data2", rd_2, rowdat(3'd6));
    tick;

    // Sparse random traffic against a scoreboard for latencies 1, 2 and 4
    rst = 1'b0; req_valid = 4'h0;
    tick;
    rst = 1'b1;
    ptr_m = 0;
    for (int i = 0; i < 80; i++) begin
      sid1[i] = 4'd0; sid2[i] = 4'd0; sid4[i] = 4'd0;
      sad1[i] = 3'd0; sad2[i] = 3'd0; sad4[i] = 3'd0;
    end
    for (int cy = 0; cy < 60; cy++) begin
      req_valid = (cy < 50 && $urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      req_addr  = 12'($urandom);
      g = rr_pick(ptr_m, req_valid);
      if (g != 4'd0) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (g[i]) idx = i;
        ptr_m = (idx + 1) % 4;
        a = req_addr[idx*3 +: 3];
        sid1[cy + 2] = g; sad1[cy + 2] = a;
        sid2[cy + 3] = g; sad2[cy + 3] = a;
        sid4[cy + 5] = g; sad4[cy + 5] = a;
      end
      #1;
      chk("sb_ready2", rr_2, g);
      chk("sb_ready1", rr_1, g);
      chk("sb_ready4", rr_4, g);
      chk("sb_resp2", rv_2, sid2[cy]);
      chk("sb_resp1", rv_1, sid1[cy]);
      chk("sb_resp4", rv_4, sid4[cy]);
      if (sid2[cy] != 4'd0) chk("sb_data2", rd_2, rowdat(sad2[cy]));
      if (sid1[cy] != 4'd0) chk("sb_data1", rd_1, rowdat(sad1[cy]));
      if (sid4[cy] != 4'd0) chk("sb_data4", rd_4, rowdat(sad4[cy]));
      tick;
    end
    #1;
    chk("sb_perr2", pe_2, 0);
    chk("sb_perr1", pe_1, 0);
    chk("sb_perr4", pe_4, 0);

    // Stray mem_valid with no tag in flight
    req_valid = 4'h0;
    inject = 1'b1;
    #1;
    chk("err_resp_sup", rv_2, 0);
    chk("err_not_yet", pe_2, 0);
    tick;
    inject = 1'b0;
    #1; chk("err_set", pe_2, 1);
    tick; tick; tick;
    #1;
    chk("err_sticky", pe_2, 1);
    chk("err_other_inst", pe_4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
